jpeg_byte_stuffer: RTL and testbench

//  Downstream stage of the JPEG entropy coder. Accepts variable-length code words
//  (Huffman code plus appended bits, MSB first) from the code packer and repacks

---
 rtl/jpeg_pkg.sv | 10 +
 rtl/jpeg_bit_acc.sv | 54 +++++
 rtl/jpeg_byte_stuffer.sv | 73 +++++++
 tb/tb_jpeg_byte_stuffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and state type for the JPEG entropy-coder output stages.
package jpeg_pkg;
  localparam int MAX_LEN = 16;
  localparam int ACC_W   = 32;
  localparam int FILL_W  = $clog2(ACC_W + 1);
  localparam logic [7:0] BYTE_FF    = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;

  typedef enum logic [1:0] {RUN, PAD, DRAIN, DONE} stuff_state_t;
endpackage

// File: rtl/jpeg_bit_acc.sv
// MSB-aligned bit accumulator: merges code words below the fill point,
// shifts out whole bytes and pads a partial final byte with 1s.
module jpeg_bit_acc
  import jpeg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [15:0]       code,
  input  logic [4:0]        len,
  input  logic              pop,
  input  logic              pad,
  output logic [7:0]        top_byte,
  output logic [FILL_W-1:0] fill
);
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ones;
  logic [ACC_W-1:0]  acc_shift;
  logic [ACC_W-1:0]  code_ext;
  logic [ACC_W-1:0]  merge;
  logic [ACC_W-1:0]  pad_mask;
  logic [FILL_W-1:0] fill_base;
  logic [FILL_W-1:0] fill_p7;
  logic [FILL_W-1:0] fill_round;
  logic [FILL_W:0]   sh;

  // Pop happens before merge so the new code lands below the post-shift fill.
  always_comb begin
    ones       = '1;
    acc_shift  = pop ? (acc << 8) : acc;
    fill_base  = pop ? (fill - FILL_W'(8)) : fill;
    code_ext   = ACC_W'(code) & ~(ones << len);
    sh         = (FILL_W+1)'(ACC_W) - {1'b0, fill_base} - (FILL_W+1)'(len);
    merge      = accept ? (code_ext << sh) : '0;
    fill_p7    = fill + FILL_W'(7);
    fill_round = {fill_p7[FILL_W-1:3], 3'b000};
    pad_mask   = (ones >> fill) & ~(ones >> fill_round);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc  <= '0;
      fill <= '0;
    end else if (pad) begin
      acc  <= acc | pad_mask;
      fill <= fill_round;
    end else begin
      acc  <= acc_shift | merge;
      fill <= fill_base + (accept ? FILL_W'(len) : FILL_W'(0));
    end
  end

  assign top_byte = acc[ACC_W-1 -: 8];
endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Repacks variable-length code words into a byte stream with 0xFF/0x00 stuffing,
// 1-padding and a done pulse on flush.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_code,
  input  logic [4:0]   in_len,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         done,
  output stuff_state_t state_dbg
);
  // Both sides use valid/ready: a transfer happens on a cycle where valid and
  // ready are both high; a raised valid and its data hold until that cycle.
  stuff_state_t      state;
  logic              stuff_pend;
  logic [FILL_W-1:0] fill;
  logic [7:0]        top_byte;
  logic [4:0]        len_c;
  logic              accept;
  logic              hs;
  logic              pop;
  logic              emit_state;

  assign len_c      = (in_len > 5'd16) ? 5'd16 : in_len;
  assign in_ready   = reset && (state == RUN) && (fill <= FILL_W'(ACC_W - MAX_LEN));
  assign accept     = in_valid && in_ready;
  assign emit_state = (state == RUN) || (state == DRAIN);
  assign out_valid  = emit_state && (stuff_pend || (fill >= FILL_W'(8)));
  assign out_byte   = stuff_pend ? STUFF_BYTE : top_byte;
  assign hs         = out_valid && out_ready;
  assign pop        = hs && !stuff_pend;
  assign done       = (state == DONE);
  assign state_dbg  = state;

  jpeg_bit_acc u_acc (
    .clk      (clk),
    .reset    (reset),
    .accept   (accept),
    .code     (in_code),
    .len      (len_c),
    .pop      (pop),
    .pad      (state == PAD),
    .top_byte (top_byte),
    .fill     (fill)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      stuff_pend <= 1'b0;
    end else begin
      if (hs && stuff_pend)
        stuff_pend <= 1'b0;
      else if (pop && (top_byte == BYTE_FF))
        stuff_pend <= 1'b1;

      case (state)
        RUN:     if (flush) state <= PAD;
        PAD:     state <= DRAIN;
        DRAIN:   if ((fill == '0) && !stuff_pend) state <= DONE;
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Self-checking bench: bit-queue reference model of packing, stuffing and padding.
module tb_jpeg_byte_stuffer;
  import jpeg_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_code = '0;
  logic [4:0]   in_len = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_byte;
  logic         done;
  stuff_state_t state_dbg;

  always #5 clk = ~clk;

  jpeg_byte_stuffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_len    (in_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .done      (done),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit         bit_q[$];
  logic [7:0] exp_q[$];
  bit         stuff_q[$];
  logic [7:0] got_q[$];
  int mode = 0;
  int done_cnt = 0;
  int d0;
  bit acc_flag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bits held inside the stage: loose bits plus every unsent data byte.
  function automatic int model_fill();
    int n = bit_q.size();
    foreach (stuff_q[i]) if (!stuff_q[i]) n += 8;
    return n;
  endfunction

  function automatic void form_bytes();
    while (bit_q.size() >= 8) begin
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bit_q.pop_front()};
      exp_q.push_back(b);
      stuff_q.push_back(1'b0);
      if (b == 8'hFF) begin
        exp_q.push_back(8'h00);
        stuff_q.push_back(1'b1);
      end
    end
  endfunction

  function automatic void push_code(input logic [15:0] c, input int len);
    int l = (len > 16) ? 16 : len;
    for (int i = l - 1; i >= 0; i--) bit_q.push_back(c[i]);
    form_bytes();
  endfunction

  task automatic observe();
    if (mode == 0) begin
      check("in_ready", in_ready, model_fill() <= 16);
      check("done_idle", done, 0);
      check("out_valid", out_valid, exp_q.size() != 0);
    end else begin
      check("in_ready_flush", in_ready, 0);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) check("extra_byte", out_byte, 32'h100);
      else begin
        check("out_byte", out_byte, exp_q[0]);
        if (out_ready) begin
          got_q.push_back(out_byte);
          void'(exp_q.pop_front());
          void'(stuff_q.pop_front());
        end
      end
    end
    if (mode == 1) begin
      if (done) begin
        done_cnt++;
        check("done_empty", exp_q.size(), 0);
        mode = 0;
      end
    end else begin
      if (in_valid && in_ready) begin
        push_code(in_code, int'(in_len));
        acc_flag = 1'b1;
      end
      if (flush) begin
        while (bit_q.size() % 8 != 0) bit_q.push_back(1'b1);
        form_bytes();
        mode = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] c, input logic [4:0] l);
    in_code  = c;
    in_len   = l;
    in_valid = 1'b1;
    acc_flag = 1'b0;
    for (int i = 0; i < 200 && !acc_flag; i++) tick();
    if (!acc_flag) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 500 && mode == 1; i++) tick();
    check("drain_timeout", mode, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bit_q.delete();
    exp_q.delete();
    stuff_q.delete();
    mode = 0;
    check("rst_out_valid", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_byte", out_byte, 8'h00);
    check("reset_done", done, 0);
    check("reset_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    check("post_reset_ready", in_ready, 1);

    // T1: two short codes pack into one byte
    out_ready = 1'b1;
    got_q.delete();
    send(16'h0016, 5'd5);
    send(16'h0003, 5'd3);
    idle(3);
    check("t1_count", got_q.size(), 1);
    check("t1_byte", got_q[0], 8'hB3);
    check("t1_fill", model_fill(), 0);

    // T2: 0xFF inside a 16-bit word gets stuffed
    got_q.delete();
    send(16'hFF12, 5'd16);
    idle(5);
    check("t2_count", got_q.size(), 3);
    check("t2_b0", got_q[0], 8'hFF);
    check("t2_b1", got_q[1], 8'h00);
    check("t2_b2", got_q[2], 8'h12);

    // T3: partial byte padded with 1s on flush
    got_q.delete();
    d0 = done_cnt;
    send(16'h0005, 5'd3);
    do_flush();
    check("t3_count", got_q.size(), 1);
    check("t3_byte", got_q[0], 8'hBF);
    check("t3_done", done_cnt - d0, 1);
    check("t3_ready_after", in_ready, 1);

    // T4: backpressure fills the accumulator
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_code  = 16'($urandom);
      in_len   = 5'd16;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t4_stall", in_ready, 0);
    out_ready = 1'b1;
    idle(10);
    check("t4_count", got_q.size() >= 4, 1);
    check("t4_empty", exp_q.size(), 0);

    // T5: padded 0xFF is stuffed; empty flush emits nothing
    got_q.delete();
    d0 = done_cnt;
    send(16'h000F, 5'd4);
    do_flush();
    check("t5_count", got_q.size(), 2);
    check("t5_b0", got_q[0], 8'hFF);
    check("t5_b1", got_q[1], 8'h00);
    got_q.delete();
    do_flush();
    check("t5_empty_count", got_q.size(), 0);
    check("t5_done", done_cnt - d0, 2);

    // T6: reset mid-stream discards buffered bits
    out_ready = 1'b0;
    send(16'h0ABC, 5'd12);
    check("t6_pre_valid", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    got_q.delete();
    send(16'h00A5, 5'd8);
    idle(4);
    check("t6_count", got_q.size(), 1);
    check("t6_byte", got_q[0], 8'hA5);

    // Random traffic with clamped lengths, 0xFF-heavy codes and random flushes
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_len    = 5'($urandom_range(0, 20));
      in_code   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 500 && mode == 1; i++) tick();
    do_flush();
    check("final_empty", exp_q.size(), 0);
    check("final_fill", model_fill(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
